clock_mode_ctrl: RTL
====================

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 Parameter ALARM_TIMEOUT, default 60, ring duration in sec_tick pulses (1..255).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 btn  in  5  debounced one-cycle button pulses; bit0 C, bit1 U, bit2 D, bit3 L, bit4 R.
REQ-005 sec_tick  in  1  one-cycle strobe at 1 Hz.
REQ-006 time_hh  in  5  current hours from time datapath, binary 0..23.
REQ-007 time_mm  in  6  current minutes from time datapath, binary 0..59.
REQ-008 adjust  out  1  time-datapath adjust enable; seconds frozen while high.
REQ-009 ENTH  out  1  one-cycle hour step to time datapath.
REQ-010 ENTM  out  1  one-cycle minute step to time datapath.
REQ-011 updown  out  1  step direction: 0 up, 1 down.
REQ-012 alarm_hh  out  5  stored alarm hour, 0..23.
REQ-013 alarm_mm  out  6  stored alarm minute, 0..59.
REQ-014 disp_alarm  out  1  display select: 1 shows alarm_hh/mm, 0 shows time.
REQ-015 led  out  4  bit0 armed, bit1 adjusting time, bit2 adjusting alarm, bit3 ringing.
REQ-016 buzzer  out  1  alarm sounder, high while ringing.

Function
REQ-017 FSM states SHALL be CLOCK, ADJ_TH, ADJ_TM, ADJ_AH, ADJ_AM, RINGING; all outputs registered.
REQ-018 Same-cycle button priority SHALL be C > L > R > U > D; only the winning bit acts, the rest are discarded.
REQ-019 CLOCK: C -> ADJ_TH; U sets armed; D clears armed; L/R ignored.
REQ-020 ADJ_*: C -> CLOCK; R cycles ADJ_TH->ADJ_TM->ADJ_AH->ADJ_AM->ADJ_TH; L cycles the reverse.
REQ-021 ADJ_TH/ADJ_TM: U or D SHALL pulse ENTH/ENTM respectively for exactly one cycle, one cycle after the button, with updown=0 for U, 1 for D.
REQ-022 ADJ_AH: U/D SHALL increment/decrement alarm_hh mod 24 (23+1=0, 0-1=23), one cycle after the button.
REQ-023 ADJ_AM: U/D SHALL increment/decrement alarm_mm mod 60 (59+1=0, 0-1=59); no carry into alarm_hh.
REQ-024 adjust SHALL be high exactly in ADJ_TH and ADJ_TM; disp_alarm exactly in ADJ_AH and ADJ_AM.
REQ-025 match = (time_hh==alarm_hh && time_mm==alarm_mm); trigger = rising edge of match (registered previous value).
REQ-026 CLOCK with armed=1 and trigger SHALL enter RINGING next cycle and clear the ring counter.
REQ-027 A trigger in any ADJ_* state or with armed=0 SHALL be dropped; it is not deferred.
REQ-028 RINGING: buzzer=1, led[3]=1; ring counter increments on sec_tick; reaching ALARM_TIMEOUT -> CLOCK.
REQ-029 RINGING: any btn bit SHALL dismiss -> CLOCK; the press is consumed and not reinterpreted in CLOCK.
REQ-030 armed SHALL stay set after dismiss or timeout; same minute does not retrigger (edge only).

Reset
REQ-031 rst SHALL immediately force state CLOCK, armed=0, alarm_hh=0, alarm_mm=0, match history=1, ring counter=0, all outputs 0.
REQ-032 Reset asserted mid-RINGING or mid-adjust SHALL abort with no ENTH/ENTM pulse after rst deassertion.

Configuration
REQ-033 Macro CLOCK_MODE_SNOOZE_EN: when defined, U in RINGING SHALL snooze: state -> CLOCK, snooze target = current time + 5 min (mod 24 h), and the alarm fires again on reaching it as if armed; other buttons dismiss and cancel any pending snooze.
REQ-034 Without CLOCK_MODE_SNOOZE_EN, no snooze logic is built and every button dismisses per REQ-029.

Verification
REQ-035 Reset, then C, R, R, U pulses -> state ADJ_AH, alarm_hh=1, disp_alarm=1, adjust=0, no ENTH/ENTM.
REQ-036 In ADJ_TH press D -> ENTH=1 for one cycle with updown=1; ENTM stays 0; adjust=1 throughout.
REQ-037 ADJ_AM with alarm_mm=59, press U -> alarm_mm=0, alarm_hh unchanged; press D -> 59.
REQ-038 Armed, alarm 07:30, drive time 07:29->07:30 -> buzzer=1 next cycle; after 60 sec_ticks -> buzzer=0, state CLOCK, armed=1.
REQ-039 RINGING, btn C and U same cycle -> dismiss to CLOCK; armed unchanged; match held at 07:30 produces no retrigger.
REQ-040 Snooze build: ringing at 23:58, press U -> buzzer=0; drive time to 00:03 -> buzzer=1.

Source files
------------

// File: rtl/clock_mode_ctrl_if.sv
// Bus between the alarm-clock mode controller and its time datapath, buttons and display.
interface clock_mode_ctrl_if;
  logic [4:0] btn;
  logic       sec_tick;
  logic [4:0] time_hh;
  logic [5:0] time_mm;
  logic       adjust;
  logic       ENTH;
  logic       ENTM;
  logic       updown;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic       disp_alarm;
  logic [3:0] led;
  logic       buzzer;

  modport master (output btn, sec_tick, time_hh, time_mm,
                  input  adjust, ENTH, ENTM, updown, alarm_hh, alarm_mm, disp_alarm, led, buzzer);
  modport slave  (input  btn, sec_tick, time_hh, time_mm,
                  output adjust, ENTH, ENTM, updown, alarm_hh, alarm_mm, disp_alarm, led, buzzer);
endinterface

// File: rtl/clock_mode_ctrl.sv
// Alarm-clock mode FSM: time/alarm adjust, arming, ringing with timeout.
// Optional snooze on U while ringing: define CLOCK_MODE_SNOOZE_EN.
module clock_mode_ctrl #(
  parameter int ALARM_TIMEOUT = 60
) (
  input  logic clk,
  input  logic rst,
  clock_mode_ctrl_if.slave bus
);
  typedef enum logic [2:0] {CLOCK, ADJ_TH, ADJ_TM, ADJ_AH, ADJ_AM, RINGING} state_t;
  typedef enum logic [2:0] {B_NONE, B_C, B_L, B_R, B_U, B_D} btn_t;

  state_t     state, state_n;
  btn_t       win;
  logic       armed, armed_n;
  logic [4:0] ah, ah_n;
  logic [5:0] am, am_n;
  logic [7:0] ring, ring_n;
  logic       match, match_q, trig, fire;
  logic       enth_n, entm_n, ud_n, adj_n, disp_n;

  always_comb begin
    win = B_NONE;
    if      (bus.btn[0]) win = B_C;
    else if (bus.btn[3]) win = B_L;
    else if (bus.btn[4]) win = B_R;
    else if (bus.btn[1]) win = B_U;
    else if (bus.btn[2]) win = B_D;
  end

  assign match = (bus.time_hh == ah) && (bus.time_mm == am);
  assign trig  = armed && match && !match_q;

`ifdef CLOCK_MODE_SNOOZE_EN
  logic       pend, pend_n, smatch, smatch_q;
  logic [4:0] sh, sh_n;
  logic [5:0] sm, sm_n;
  logic [6:0] mm5;
  assign smatch = pend && (bus.time_hh == sh) && (bus.time_mm == sm);
  assign fire   = trig || (smatch && !smatch_q);
  assign mm5    = {1'b0, bus.time_mm} + 7'd5;
`else
  assign fire = trig;
`endif

  always_comb begin
    state_n = state;
    armed_n = armed;
    ah_n    = ah;
    am_n    = am;
    ring_n  = ring;
    enth_n  = 1'b0;
    entm_n  = 1'b0;
    ud_n    = bus.updown;
`ifdef CLOCK_MODE_SNOOZE_EN
    pend_n  = pend;
    sh_n    = sh;
    sm_n    = sm;
`endif
    case (state)
      // an alarm edge outranks a button arriving in the same cycle
      CLOCK: begin
        if (fire) begin
          state_n = RINGING;
          ring_n  = 8'd0;
`ifdef CLOCK_MODE_SNOOZE_EN
          pend_n  = 1'b0;
`endif
        end else begin
          case (win)
            B_C:     state_n = ADJ_TH;
            B_U:     armed_n = 1'b1;
            B_D:     armed_n = 1'b0;
            default: ;
          endcase
        end
      end
      ADJ_TH, ADJ_TM, ADJ_AH, ADJ_AM: begin
        case (win)
          B_C: state_n = CLOCK;
          B_R: case (state)
                 ADJ_TH:  state_n = ADJ_TM;
                 ADJ_TM:  state_n = ADJ_AH;
                 ADJ_AH:  state_n = ADJ_AM;
                 default: state_n = ADJ_TH;
               endcase
          B_L: case (state)
                 ADJ_TH:  state_n = ADJ_AM;
                 ADJ_AM:  state_n = ADJ_AH;
                 ADJ_AH:  state_n = ADJ_TM;
                 default: state_n = ADJ_TH;
               endcase
          B_U, B_D: case (state)
                 ADJ_TH: begin enth_n = 1'b1; ud_n = (win == B_D); end
                 ADJ_TM: begin entm_n = 1'b1; ud_n = (win == B_D); end
                 ADJ_AH: if (win == B_D) ah_n = (ah == 5'd0)  ? 5'd23 : ah - 5'd1;
                         else            ah_n = (ah == 5'd23) ? 5'd0  : ah + 5'd1;
                 default: if (win == B_D) am_n = (am == 6'd0)  ? 6'd59 : am - 6'd1;
                          else            am_n = (am == 6'd59) ? 6'd0  : am + 6'd1;
               endcase
          default: ;
        endcase
      end
      RINGING: begin
        if (win != B_NONE) begin
          state_n = CLOCK;
`ifdef CLOCK_MODE_SNOOZE_EN
          if (win == B_U) begin
            pend_n = 1'b1;
            if (mm5 >= 7'd60) begin
              sm_n = 6'(mm5 - 7'd60);
              sh_n = (bus.time_hh == 5'd23) ? 5'd0 : bus.time_hh + 5'd1;
            end else begin
              sm_n = 6'(mm5);
              sh_n = bus.time_hh;
            end
          end else begin
            pend_n = 1'b0;
          end
`endif
        end else if (bus.sec_tick) begin
          ring_n = ring + 8'd1;
          if (ring_n == 8'(ALARM_TIMEOUT)) state_n = CLOCK;
        end
      end
      default: state_n = CLOCK;
    endcase
  end

  assign adj_n  = (state_n == ADJ_TH) || (state_n == ADJ_TM);
  assign disp_n = (state_n == ADJ_AH) || (state_n == ADJ_AM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= CLOCK;
      armed          <= 1'b0;
      ah             <= 5'd0;
      am             <= 6'd0;
      ring           <= 8'd0;
      match_q        <= 1'b1;
      bus.adjust     <= 1'b0;
      bus.ENTH       <= 1'b0;
      bus.ENTM       <= 1'b0;
      bus.updown     <= 1'b0;
      bus.disp_alarm <= 1'b0;
      bus.led        <= 4'd0;
      bus.buzzer     <= 1'b0;
    end else begin
      state          <= state_n;
      armed          <= armed_n;
      ah             <= ah_n;
      am             <= am_n;
      ring           <= ring_n;
      match_q        <= match;
      bus.adjust     <= adj_n;
      bus.ENTH       <= enth_n;
      bus.ENTM       <= entm_n;
      bus.updown     <= ud_n;
      bus.disp_alarm <= disp_n;
      bus.led        <= {state_n == RINGING, disp_n, adj_n, armed_n};
      bus.buzzer     <= (state_n == RINGING);
    end
  end

  assign bus.alarm_hh = ah;
  assign bus.alarm_mm = am;

`ifdef CLOCK_MODE_SNOOZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      sh       <= 5'd0;
      sm       <= 6'd0;
      smatch_q <= 1'b1;
    end else begin
      pend     <= pend_n;
      sh       <= sh_n;
      sm       <= sm_n;
      smatch_q <= smatch;
    end
  end
`endif
endmodule
